// File: rtl/vtiming_seq_pkg.sv
// Shared definitions for the vertical timing sequencer: default timing,
// counter widths, PROM flag bit positions and sequencer state encodings.
package vtiming_seq_pkg;

  // Default line / frame timing
  localparam int unsigned H_TOTAL_DEF       = 320;
  localparam int unsigned H_BLANK_START_DEF = 256;
  localparam int unsigned H_SYNC_START_DEF  = 280;
  localparam int unsigned H_SYNC_END_DEF    = 312;
  localparam int unsigned V_TOTAL_DEF       = 256;

  // Counter widths (vcount doubles as the 8-bit PROM address)
  localparam int HCW = 9;
  localparam int VCW = 8;

  // Bit positions inside the 4-bit PROM word (bit 3 is reserved)
  localparam int VF_IRQ    = 0;
  localparam int VF_VSYNC  = 1;
  localparam int VF_VBLANK = 2;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2
  } vt_state_e;

  // Next line number with wrap back to line 0 after the last line
  function automatic logic [VCW-1:0] next_line(input logic [VCW-1:0] cur,
                                               input logic           last);
    return last ? '0 : cur + VCW'(1);
  endfunction

endpackage

// File: rtl/vtiming_seq_line_counter.sv
// Horizontal/vertical position counters gated by the pixel clock enable.
// Also produces the registered hblank/hsync, the field bit and a one-clk
// strobe on the clock after each line wrap to kick the PROM fetch.
module line_counter
  import vtiming_seq_pkg::*;
#(
  parameter int unsigned H_TOTAL       = H_TOTAL_DEF,
  parameter int unsigned H_BLANK_START = H_BLANK_START_DEF,
  parameter int unsigned H_SYNC_START  = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_END    = H_SYNC_END_DEF,
  parameter int unsigned V_TOTAL       = V_TOTAL_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  output logic [HCW-1:0] hcount,
  output logic [VCW-1:0] vcount,
  output logic [VCW-1:0] vcount_next,
  output logic           field,
  output logic           hblank,
  output logic           hsync,
  output logic           line_end,
  output logic           line_wrap
);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] HB_START = HCW'(H_BLANK_START);
  localparam logic [HCW-1:0] HS_START = HCW'(H_SYNC_START);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_SYNC_END);

  logic [HCW-1:0] hcount_reg, hcount_next;
  logic [VCW-1:0] vcount_reg, vcount_next_c;
  logic           field_reg, field_next;
  logic           hblank_reg, hsync_reg, line_wrap_reg;
  logic           h_last, v_last, line_end_c;

  // Next-state of the counters; hold everything when ce is low
  always_comb begin
    h_last        = (hcount_reg == H_LAST);
    v_last        = (vcount_reg == V_LAST);
    line_end_c    = ce & h_last;
    hcount_next   = hcount_reg;
    if (ce) begin
      hcount_next = h_last ? '0 : hcount_reg + HCW'(1);
    end
    vcount_next_c = line_end_c ? next_line(vcount_reg, v_last) : vcount_reg;
    field_next    = field_reg ^ (line_end_c & v_last);
  end

  // Counter and decoded horizontal flag registers; flags decode the next
  // hcount so they line up with hcount after the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_reg    <= '0;
      vcount_reg    <= '0;
      field_reg     <= 1'b0;
      hblank_reg    <= 1'b0;
      hsync_reg     <= 1'b0;
      line_wrap_reg <= 1'b0;
    end else begin
      hcount_reg    <= hcount_next;
      vcount_reg    <= vcount_next_c;
      field_reg     <= field_next;
      hblank_reg    <= (hcount_next >= HB_START);
      hsync_reg     <= (hcount_next >= HS_START) && (hcount_next < HS_END);
      line_wrap_reg <= line_end_c;
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign vcount_next = vcount_next_c;
  assign field       = field_reg;
  assign hblank      = hblank_reg;
  assign hsync       = hsync_reg;
  assign line_end    = line_end_c;
  assign line_wrap   = line_wrap_reg;

endmodule

// File: rtl/vtiming_seq.sv
// Video timing sequencer. Counts pixels/lines, addresses the external
// vertical-timing PROM with the upcoming line number at each line wrap,
// latches the returned flags a fixed 3 clocks after the wrap, and raises a
// held IRQ on a rising PROM bit0 between consecutive lines.
module vtiming_seq
  import vtiming_seq_pkg::*;
#(
  parameter int unsigned H_TOTAL       = H_TOTAL_DEF,
  parameter int unsigned H_BLANK_START = H_BLANK_START_DEF,
  parameter int unsigned H_SYNC_START  = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_END    = H_SYNC_END_DEF,
  parameter int unsigned V_TOTAL       = V_TOTAL_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  output logic [VCW-1:0] prom_a,
  input  logic [3:0]     prom_d,
  output logic [HCW-1:0] hcount,
  output logic [VCW-1:0] vcount,
  output logic           hblank,
  output logic           hsync,
  output logic           vblank,
  output logic           vsync,
  output logic           irq,
  input  logic           irq_ack,
  output logic           field
);

  logic [VCW-1:0] vcount_next;
  logic           line_end, line_wrap;
  logic [VCW-1:0] prom_a_reg;
  vt_state_e      state_reg, state_next;
  logic           latch_en;
  logic           vblank_reg, vsync_reg, irq_reg, hist_reg;
  logic           irq_rise;
  logic           prom_rsvd_unused;

  // Bit 3 of the PROM word carries nothing for this block
  assign prom_rsvd_unused = prom_d[3];

  line_counter #(
    .H_TOTAL      (H_TOTAL),
    .H_BLANK_START(H_BLANK_START),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_END   (H_SYNC_END),
    .V_TOTAL      (V_TOTAL)
  ) u_line_counter (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .hcount     (hcount),
    .vcount     (vcount),
    .vcount_next(vcount_next),
    .field      (field),
    .hblank     (hblank),
    .hsync      (hsync),
    .line_end   (line_end),
    .line_wrap  (line_wrap)
  );

  // PROM address follows vcount, loaded on the same edge vcount advances
  always_ff @(posedge clk) begin
    if (reset) begin
      prom_a_reg <= '0;
    end else if (line_end) begin
      prom_a_reg <= vcount_next;
    end
  end

  // Sequencer state register; reset lands in FETCH so line 0 is re-read
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sequencer next state: wait for the wrap strobe, give the PROM one clock,
  // then capture its word
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (line_wrap) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign irq_rise = latch_en & prom_d[VF_IRQ] & ~hist_reg;

  // Vertical flags, bit0 history and the held interrupt; a new rising
  // edge of bit0 takes priority over a simultaneous acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_reg <= 1'b0;
      vsync_reg  <= 1'b0;
      hist_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (latch_en) begin
        vblank_reg <= prom_d[VF_VBLANK];
        vsync_reg  <= prom_d[VF_VSYNC];
        hist_reg   <= prom_d[VF_IRQ];
      end
      if (irq_rise) begin
        irq_reg <= 1'b1;
      end else if (irq_ack) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign prom_a = prom_a_reg;
  assign vblank = vblank_reg;
  assign vsync  = vsync_reg;
  assign irq    = irq_reg;

endmodule

// File: tb/tb_vtiming_seq.sv
// Self-checking bench for vtiming_seq. A short line length keeps whole frames
// cheap; expectations come from the count of ce pulses since reset and a
// queue of pending PROM reads, each due 3 clocks after its line wrap.
module tb_vtiming_seq;

  localparam int HT  = 20;
  localparam int HBS = 14;
  localparam int HSS = 16;
  localparam int HSE = 18;
  localparam int VT  = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       irq_ack = 1'b0;
  logic [3:0] prom_d = 4'h0;
  logic [7:0] prom_a;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       hblank, hsync, vblank, vsync, irq, field;

  always #5 clk = ~clk;

  vtiming_seq #(
    .H_TOTAL      (HT),
    .H_BLANK_START(HBS),
    .H_SYNC_START (HSS),
    .H_SYNC_END   (HSE),
    .V_TOTAL      (VT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .prom_a (prom_a),
    .prom_d (prom_d),
    .hcount (hcount),
    .vcount (vcount),
    .hblank (hblank),
    .hsync  (hsync),
    .vblank (vblank),
    .vsync  (vsync),
    .irq    (irq),
    .irq_ack(irq_ack),
    .field  (field)
  );

  // PROM contents used by the bench
  function automatic logic [3:0] rom_word(input int a);
    if (a == 'h5e) return 4'b0001;
    if (a == 'h5f) return 4'b0100;
    if (a >= 'he0 && a <= 'hf9) return 4'b0100;
    if (a >= 'hfa && a <= 'hfd) return 4'b0110;
    return 4'b0000;
  endfunction

  // Synchronous PROM with one clock of read latency
  always @(posedge clk) prom_d <= rom_word(int'(prom_a));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model state
  typedef struct { longint due; int line; } pend_t;
  pend_t       pq[$];
  longint      cyc = 0;
  int unsigned n = 0;
  logic        prev_rst = 1'b1;
  logic        m_vblank = 0, m_vsync = 0, m_irq = 0, m_hist = 0;
  logic        last_irq = 0;

  task automatic model_edge();
    logic [3:0] d;
    logic       set;
    cyc++;
    if (reset) begin
      n = 0;
      pq.delete();
      m_vblank = 0; m_vsync = 0; m_irq = 0; m_hist = 0;
    end else begin
      if (prev_rst) pq.push_back('{cyc + 1, 0});
      set = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        d = rom_word(pq[0].line);
        void'(pq.pop_front());
        m_vblank = d[2];
        m_vsync  = d[1];
        set      = d[0] && !m_hist;
        m_hist   = d[0];
      end
      if (set) m_irq = 1'b1;
      else if (irq_ack) m_irq = 1'b0;
      if (ce) begin
        n++;
        if (n % HT == 0) pq.push_back('{cyc + 3, int'((n / HT) % VT)});
      end
    end
    prev_rst = reset;
  endtask

  task automatic compare_all();
    int h, v;
    h = int'(n % HT);
    v = int'((n / HT) % VT);
    check_val("hcount", 32'(hcount), 32'(h));
    check_val("vcount", 32'(vcount), 32'(v));
    check_val("prom_a", 32'(prom_a), 32'(v));
    check_val("hblank", 32'(hblank), 32'(h >= HBS));
    check_val("hsync",  32'(hsync),  32'(h >= HSS && h < HSE));
    check_val("vblank", 32'(vblank), 32'(m_vblank));
    check_val("vsync",  32'(vsync),  32'(m_vsync));
    check_val("irq",    32'(irq),    32'(m_irq));
    check_val("field",  32'(field),  32'((n / (HT * VT)) % 2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (irq !== last_irq) begin
      $display("irq -> %0b at line %02h cycle %0d", irq, vcount, cyc);
      last_irq = irq;
    end
  endtask

  initial begin
    int  k;
    bit  armed;
    // Reset with ce held high
    reset = 1'b1; ce = 1'b1; irq_ack = 1'b0;
    repeat (3) tick();
    check_val("rst_hcount", 32'(hcount), 0);
    check_val("rst_irq", 32'(irq), 0);
    reset = 1'b0;
    repeat (3) tick();
    check_val("post_rst_vblank", 32'(vblank), 0);
    $display("reset released, free running");

    // Run to line 0x60: irq from line 0x5e must still be held
    k = 0;
    while (!(vcount == 8'h60 && hcount == 9'd5) && k < 20000) begin tick(); k++; end
    check_val("reach_60_timeout", 32'(k < 20000), 1);
    check_val("irq_held", 32'(irq), 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check_val("irq_acked", 32'(irq), 0);
    $display("irq acked at line %02h", vcount);

    // Next frame: acknowledge on the exact latch clock of line 0x5e
    armed = 0; k = 0;
    while (!(armed && vcount == 8'h61) && k < 12000) begin
      irq_ack = (pq.size() > 0 && pq[0].due == cyc + 1 && pq[0].line == 'h5e);
      if (irq_ack) armed = 1;
      tick(); k++;
    end
    irq_ack = 1'b0;
    check_val("set_wins_armed", 32'(armed), 1);
    check_val("set_wins_irq", 32'(irq), 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check_val("irq_acked2", 32'(irq), 0);
    $display("set-vs-ack collision done");

    // Random ce and sparse random acknowledges
    for (int i = 0; i < 8000; i++) begin
      ce      = 1'($urandom_range(0, 1));
      irq_ack = ($urandom_range(0, 99) == 0);
      tick();
    end
    irq_ack = 1'b0;
    $display("random phase done, line %02h", vcount);

    // ce 1-in-4; reset mid-fetch on line 0x10
    k = 0;
    ce = (cyc % 4 == 0);
    while (!(vcount == 8'h10 && pq.size() > 0 && pq[0].due == cyc + 2) && k < 30000) begin
      tick(); k++;
      ce = (cyc % 4 == 0);
    end
    check_val("midfetch_timeout", 32'(k < 30000), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("midrst_hcount", 32'(hcount), 0);
    check_val("midrst_vcount", 32'(vcount), 0);
    check_val("midrst_vblank", 32'(vblank), 0);
    $display("reset mid-fetch applied");
    for (int i = 0; i < HT * VT * 4 + 100; i++) begin
      ce = (cyc % 4 == 0);
      tick();
    end
    check_val("field_toggled", 32'(field), 1);
    $display("field toggle phase done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
